depth_lb_ctrl: RTL and testbench
================================

DEPTH_LB_CTRL -- requirements
Module: depth_lb_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_LINES, 64, resident rows and SRAM bank count; power of 2, 2..128.
- DEPTH_BW, 16, depth sample width.
- H_BW, 10, column index width.
- V_BW, 10, row index width.
- Z_BW, 32, transformed-z width.
- MUL, 16, fraction bits of z.
- MIN_DEPTH / MAX_DEPTH / MAX_DIFF, 0 / 'hFFFF / 'h100, depth validity bounds in integer depth units.
REQ-002 Ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset.
- i_frame_start, in, 1, clears write position and row tags.
- r_hsize / r_vsize, in, H_BW / V_BW, frame size, static within a frame.
- i_wr_valid / i_wr_depth, in, 1 / DEPTH_BW, raster-order depth write stream.
- i_rd_valid, in, 1, lookup request.
- i_rd_x / i_rd_y, in, H_BW / V_BW, lookup position.
- i_rd_z, in, Z_BW, expected z, unsigned, MUL fraction bits.
- o_sram_wen, out, [NUM_LINES]x1, port-A write enable, active low.
- o_sram_aa / o_sram_da, out, [NUM_LINES]xH_BW / DEPTH_BW, port-A address and data.
- o_sram_ab, out, [NUM_LINES]xH_BW, port-B read address.
- i_sram_qb, in, [NUM_LINES]xDEPTH_BW, port-B data, valid 1 cycle after address.
- o_valid, out, 1, lookup passed all checks.
- o_miss, out, 1, lookup row not resident.
- o_rd_x / o_rd_y, out, H_BW / V_BW, aligned lookup position.
- o_depth0 / o_depth1, out, DEPTH_BW, depth at rows y and y+1.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low (i_clk, i_rst_n).

Function
REQ-004 Write counters wx/wy shall advance on i_wr_valid; wx wraps at r_hsize-1; wy increments on wx wrap and wraps at r_vsize-1 to 0.
REQ-005 Write bank shall be wy mod NUM_LINES; the registered write shall drive only that bank: wen=0, aa=wx, da=depth. All other banks get wen=1, aa=all-ones, da=0.
REQ-006 Each bank shall keep a tag {valid, row} of width 1+V_BW.
- Write with wx==0 clears valid.
- Write with wx==r_hsize-1 sets valid and row=wy.
REQ-007 i_frame_start shall zero wx/wy and all tag valids. A write in the same cycle lands at (0,0) and applies the REQ-006 update after the clear.
REQ-008 A row r is resident iff tag[r mod NUM_LINES] is valid with row==r. Residency shall be sampled in the cycle i_rd_valid is high.
REQ-009 Read issue: the cycle after i_rd_valid, ab of banks y mod N and (y+1) mod N shall be i_rd_x. All other banks get all-ones.
REQ-010 Fixed latency of 4 cycles from i_rd_valid to output; one request per cycle accepted, no backpressure.
REQ-011 o_depth0 = bank y data if row y resident, else 0. o_depth1 = bank y+1 data if y+1<r_vsize and row y+1 resident, else 0.
REQ-012 o_miss = 1 iff row y was not resident at issue.
REQ-013 o_valid = 1 iff all of the following hold at issue:
- row y resident;
- MIN_DEPTH < depth0 < MAX_DEPTH, strict;
- |i_rd_z - (depth0<<MUL)| < (MAX_DIFF<<MUL).
The difference shall be computed at Z_BW+1 bits with no wrap. o_depth1 does not affect o_valid.
REQ-014 o_valid and o_miss shall be single-cycle pulses, 0 in cycles with no returning request. o_rd_x/o_rd_y/o_depth* hold their last value.
REQ-015 NUM_LINES==2 with y odd: both rows map to distinct banks. Bank index arithmetic shall wrap modulo NUM_LINES.

Reset
REQ-016 While i_rst_n==0 at a clock edge, the following shall apply:
- all tags invalid; wx=wy=0;
- all wen=1, all aa/ab all-ones, da=0;
- o_valid=o_miss=0;
- o_depth*/o_rd_* = 0;
- in-flight requests discarded.
REQ-017 Reset mid-frame requires i_frame_start before further writes are meaningful. Lookups after reset return o_miss=1.

Verification
REQ-018 NUM_LINES=4, hsize=8, write rows 0-1 with depth=100, then read (3,0) with z=100<<16 -> 4 cycles later o_valid=1, o_miss=0, o_depth0=o_depth1=100.
REQ-019 Same fill, read (3,2) -> o_miss=1, o_valid=0, o_depth0=0.
REQ-020 Write rows 0-4, read (0,0) -> o_miss=1 (bank reused by row 4). Read (0,4) -> o_miss=0.
REQ-021 Row 0 depth=100, z=(100+MAX_DIFF)<<16 -> o_valid=0. Same with z=(100+MAX_DIFF-1)<<16 -> o_valid=1. depth0=MAX_DEPTH -> o_valid=0.
REQ-022 Back-to-back reads every cycle for 16 cycles, concurrent with writes to another row -> 16 consecutive correct outputs, no write corruption.
REQ-023 Reset asserted with 2 requests in flight -> no o_valid/o_miss pulse afterwards. A read issued before i_frame_start -> o_miss=1.

Source files
------------

// File: rtl/depth_lb_ctrl.sv
// Depth line-buffer controller: steers a raster depth stream into NUM_LINES SRAM banks
// and serves 4-cycle fixed-latency two-row lookups with residency and z-consistency checks.
module depth_lb_ctrl #(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned DEPTH_BW  = 16,
  parameter int unsigned H_BW      = 10,
  parameter int unsigned V_BW      = 10,
  parameter int unsigned Z_BW      = 32,
  parameter int unsigned MUL       = 16,
  parameter int unsigned MIN_DEPTH = 0,
  parameter int unsigned MAX_DEPTH = 'hFFFF,
  parameter int unsigned MAX_DIFF  = 'h100
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_frame_start,
  input  logic [H_BW-1:0]                    r_hsize,
  input  logic [V_BW-1:0]                    r_vsize,
  input  logic                               i_wr_valid,
  input  logic [DEPTH_BW-1:0]                i_wr_depth,
  input  logic                               i_rd_valid,
  input  logic [H_BW-1:0]                    i_rd_x,
  input  logic [V_BW-1:0]                    i_rd_y,
  input  logic [Z_BW-1:0]                    i_rd_z,
  output logic [NUM_LINES-1:0]               o_sram_wen,
  output logic [NUM_LINES-1:0][H_BW-1:0]     o_sram_aa,
  output logic [NUM_LINES-1:0][DEPTH_BW-1:0] o_sram_da,
  output logic [NUM_LINES-1:0][H_BW-1:0]     o_sram_ab,
  input  logic [NUM_LINES-1:0][DEPTH_BW-1:0] i_sram_qb,
  output logic                               o_valid,
  output logic                               o_miss,
  output logic [H_BW-1:0]                    o_rd_x,
  output logic [V_BW-1:0]                    o_rd_y,
  output logic [DEPTH_BW-1:0]                o_depth0,
  output logic [DEPTH_BW-1:0]                o_depth1
);

  localparam int unsigned LW = $clog2(NUM_LINES);
  localparam int unsigned CW = Z_BW + 1;
  localparam logic [DEPTH_BW-1:0] MinDepth = DEPTH_BW'(MIN_DEPTH);
  localparam logic [DEPTH_BW-1:0] MaxDepth = DEPTH_BW'(MAX_DEPTH);
  localparam logic [CW-1:0]       DiffLim  = CW'(MAX_DIFF) << MUL;

  // Write side state
  logic [H_BW-1:0]                    wx_q, wx_d;
  logic [V_BW-1:0]                    wy_q, wy_d;
  logic [NUM_LINES-1:0]               tag_vld_q, tag_vld_d;
  logic [NUM_LINES-1:0][V_BW-1:0]     tag_row_q, tag_row_d;
  logic [NUM_LINES-1:0]               wen_q, wen_d;
  logic [NUM_LINES-1:0][H_BW-1:0]     aa_q, aa_d;
  logic [NUM_LINES-1:0][DEPTH_BW-1:0] da_q, da_d;
  logic [NUM_LINES-1:0][H_BW-1:0]     ab_q, ab_d;

  // Lookup pipeline
  logic                s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  logic [H_BW-1:0]     s1_x_q, s1_x_d, s2_x_q, s2_x_d, s3_x_q, s3_x_d;
  logic [V_BW-1:0]     s1_y_q, s1_y_d, s2_y_q, s2_y_d, s3_y_q, s3_y_d;
  logic [Z_BW-1:0]     s1_z_q, s1_z_d, s2_z_q, s2_z_d, s3_z_q, s3_z_d;
  logic                s1_res0_q, s1_res0_d, s2_res0_q, s2_res0_d, s3_res0_q, s3_res0_d;
  logic                s1_res1_q, s1_res1_d, s2_res1_q, s2_res1_d;
  logic [DEPTH_BW-1:0] s3_d0_q, s3_d0_d, s3_d1_q, s3_d1_d;

  logic                valid_q, valid_d, miss_q, miss_d;
  logic [H_BW-1:0]     rd_x_q, rd_x_d;
  logic [V_BW-1:0]     rd_y_q, rd_y_d;
  logic [DEPTH_BW-1:0] depth0_q, depth0_d, depth1_q, depth1_d;

  logic [H_BW-1:0] pos_x, hlast;
  logic [V_BW-1:0] pos_y, vlast;
  logic [LW-1:0]   wbank, rb0, rb1, sb0, sb1;
  logic [V_BW:0]   rd_y1;
  logic [CW-1:0]   z_ext, d_ext, diff;

  assign hlast = r_hsize - H_BW'(1);
  assign vlast = r_vsize - V_BW'(1);

  always_comb begin
    // Write position, tags and port-A
    wx_d      = wx_q;
    wy_d      = wy_q;
    tag_vld_d = tag_vld_q;
    tag_row_d = tag_row_q;
    wen_d     = '1;
    aa_d      = '1;
    da_d      = '0;
    pos_x     = i_frame_start ? '0 : wx_q;
    pos_y     = i_frame_start ? '0 : wy_q;
    wbank     = pos_y[LW-1:0];
    if (i_frame_start) begin
      wx_d      = '0;
      wy_d      = '0;
      tag_vld_d = '0;
    end
    if (i_wr_valid) begin
      wen_d[wbank] = 1'b0;
      aa_d[wbank]  = pos_x;
      da_d[wbank]  = i_wr_depth;
      // A bank's row becomes resident only once its last column has landed
      if (pos_x == '0) tag_vld_d[wbank] = 1'b0;
      if (pos_x == hlast) begin
        tag_vld_d[wbank] = 1'b1;
        tag_row_d[wbank] = pos_y;
        wx_d             = '0;
        wy_d             = (pos_y == vlast) ? '0 : pos_y + V_BW'(1);
      end else begin
        wx_d = pos_x + H_BW'(1);
      end
    end

    // Issue: residency sampled against the tags as they stand in the request cycle
    rb0       = i_rd_y[LW-1:0];
    rb1       = rb0 + LW'(1);
    rd_y1     = {1'b0, i_rd_y} + (V_BW+1)'(1);
    s1_vld_d  = i_rd_valid;
    s1_x_d    = i_rd_x;
    s1_y_d    = i_rd_y;
    s1_z_d    = i_rd_z;
    s1_res0_d = tag_vld_q[rb0] && (tag_row_q[rb0] == i_rd_y);
    s1_res1_d = (rd_y1 < {1'b0, r_vsize}) && tag_vld_q[rb1] &&
                (tag_row_q[rb1] == rd_y1[V_BW-1:0]);
    ab_d      = '1;
    if (i_rd_valid) begin
      ab_d[rb0] = i_rd_x;
      ab_d[rb1] = i_rd_x;
    end

    // SRAM read in flight
    s2_vld_d  = s1_vld_q;
    s2_x_d    = s1_x_q;
    s2_y_d    = s1_y_q;
    s2_z_d    = s1_z_q;
    s2_res0_d = s1_res0_q;
    s2_res1_d = s1_res1_q;

    // Capture port-B data
    sb0       = s2_y_q[LW-1:0];
    sb1       = sb0 + LW'(1);
    s3_vld_d  = s2_vld_q;
    s3_x_d    = s2_x_q;
    s3_y_d    = s2_y_q;
    s3_z_d    = s2_z_q;
    s3_res0_d = s2_res0_q;
    s3_d0_d   = s2_res0_q ? i_sram_qb[sb0] : '0;
    s3_d1_d   = s2_res1_q ? i_sram_qb[sb1] : '0;

    // Checks; the extra top bit keeps the z difference from wrapping
    z_ext    = {1'b0, s3_z_q};
    d_ext    = CW'(s3_d0_q) << MUL;
    diff     = (z_ext >= d_ext) ? z_ext - d_ext : d_ext - z_ext;
    valid_d  = s3_vld_q && s3_res0_q && (s3_d0_q > MinDepth) && (s3_d0_q < MaxDepth) &&
               (diff < DiffLim);
    miss_d   = s3_vld_q && !s3_res0_q;
    rd_x_d   = s3_vld_q ? s3_x_q  : rd_x_q;
    rd_y_d   = s3_vld_q ? s3_y_q  : rd_y_q;
    depth0_d = s3_vld_q ? s3_d0_q : depth0_q;
    depth1_d = s3_vld_q ? s3_d1_q : depth1_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wx_q      <= '0;
      wy_q      <= '0;
      tag_vld_q <= '0;
      tag_row_q <= '0;
      wen_q     <= '1;
      aa_q      <= '1;
      da_q      <= '0;
      ab_q      <= '1;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s2_x_q    <= '0;
      s3_x_q    <= '0;
      s1_y_q    <= '0;
      s2_y_q    <= '0;
      s3_y_q    <= '0;
      s1_z_q    <= '0;
      s2_z_q    <= '0;
      s3_z_q    <= '0;
      s1_res0_q <= 1'b0;
      s2_res0_q <= 1'b0;
      s3_res0_q <= 1'b0;
      s1_res1_q <= 1'b0;
      s2_res1_q <= 1'b0;
      s3_d0_q   <= '0;
      s3_d1_q   <= '0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      depth0_q  <= '0;
      depth1_q  <= '0;
    end else begin
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      tag_vld_q <= tag_vld_d;
      tag_row_q <= tag_row_d;
      wen_q     <= wen_d;
      aa_q      <= aa_d;
      da_q      <= da_d;
      ab_q      <= ab_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s3_vld_q  <= s3_vld_d;
      s1_x_q    <= s1_x_d;
      s2_x_q    <= s2_x_d;
      s3_x_q    <= s3_x_d;
      s1_y_q    <= s1_y_d;
      s2_y_q    <= s2_y_d;
      s3_y_q    <= s3_y_d;
      s1_z_q    <= s1_z_d;
      s2_z_q    <= s2_z_d;
      s3_z_q    <= s3_z_d;
      s1_res0_q <= s1_res0_d;
      s2_res0_q <= s2_res0_d;
      s3_res0_q <= s3_res0_d;
      s1_res1_q <= s1_res1_d;
      s2_res1_q <= s2_res1_d;
      s3_d0_q   <= s3_d0_d;
      s3_d1_q   <= s3_d1_d;
      valid_q   <= valid_d;
      miss_q    <= miss_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      depth0_q  <= depth0_d;
      depth1_q  <= depth1_d;
    end
  end

  assign o_sram_wen = wen_q;
  assign o_sram_aa  = aa_q;
  assign o_sram_da  = da_q;
  assign o_sram_ab  = ab_q;
  assign o_valid    = valid_q;
  assign o_miss     = miss_q;
  assign o_rd_x     = rd_x_q;
  assign o_rd_y     = rd_y_q;
  assign o_depth0   = depth0_q;
  assign o_depth1   = depth1_q;

endmodule

// File: tb/tb_depth_lb_ctrl.sv
// Directed bench for depth_lb_ctrl: 4 banks, 8-pixel rows, behavioural dual-port SRAMs.
module tb_depth_lb_ctrl;

  localparam int unsigned NL = 4;
  localparam int unsigned HB = 10;
  localparam int unsigned VB = 10;
  localparam int unsigned DB = 16;
  localparam int unsigned ZB = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   frame_start;
  logic [HB-1:0]          hsize;
  logic [VB-1:0]          vsize;
  logic                   wr_valid;
  logic [DB-1:0]          wr_depth;
  logic                   rd_valid;
  logic [HB-1:0]          rd_x;
  logic [VB-1:0]          rd_y;
  logic [ZB-1:0]          rd_z;
  logic [NL-1:0]          sram_wen;
  logic [NL-1:0][HB-1:0]  sram_aa;
  logic [NL-1:0][DB-1:0]  sram_da;
  logic [NL-1:0][HB-1:0]  sram_ab;
  logic [NL-1:0][DB-1:0]  sram_qb;
  logic                   o_valid;
  logic                   o_miss;
  logic [HB-1:0]          o_rd_x;
  logic [VB-1:0]          o_rd_y;
  logic [DB-1:0]          o_depth0;
  logic [DB-1:0]          o_depth1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  depth_lb_ctrl #(.NUM_LINES(NL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(frame_start),
    .r_hsize      (hsize),
    .r_vsize      (vsize),
    .i_wr_valid   (wr_valid),
    .i_wr_depth   (wr_depth),
    .i_rd_valid   (rd_valid),
    .i_rd_x       (rd_x),
    .i_rd_y       (rd_y),
    .i_rd_z       (rd_z),
    .o_sram_wen   (sram_wen),
    .o_sram_aa    (sram_aa),
    .o_sram_da    (sram_da),
    .o_sram_ab    (sram_ab),
    .i_sram_qb    (sram_qb),
    .o_valid      (o_valid),
    .o_miss       (o_miss),
    .o_rd_x       (o_rd_x),
    .o_rd_y       (o_rd_y),
    .o_depth0     (o_depth0),
    .o_depth1     (o_depth1)
  );

  // Behavioural SRAM banks: port-A write, port-B registered read
  logic [DB-1:0] mem [NL][1024];
  always_ff @(posedge clk) begin
    for (int b = 0; b < NL; b++) begin
      if (!sram_wen[b]) mem[b][sram_aa[b]] <= sram_da[b];
      sram_qb[b] <= mem[b][sram_ab[b]];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] exp_depth(input int row, input int x);
    case (row)
      0, 1:    return 16'd100;
      2:       return 16'(65535 - x);
      3:       return 16'(10 * x);
      4:       return 16'(200 + x);
      default: return 16'(300 + x);
    endcase
  endfunction

  task automatic write_row(input int row);
    logic [NL-1:0] ew;
    for (int x = 0; x < 8; x++) begin
      wr_valid = 1'b1;
      wr_depth = exp_depth(row, x);
      @(posedge clk); #1;
      if (x == 5) begin
        ew = '1;
        ew[row % NL] = 1'b0;
        check_eq("wr_wen", 64'(sram_wen), 64'(ew));
        check_eq("wr_aa", 64'(sram_aa[row % NL]), 64'd5);
        check_eq("wr_da", 64'(sram_da[row % NL]), 64'(exp_depth(row, 5)));
        check_eq("wr_aa_idle", 64'(sram_aa[(row + 1) % NL]), 64'h3FF);
        check_eq("wr_da_idle", 64'(sram_da[(row + 1) % NL]), 64'd0);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input int x, input int y, input int zd,
                         input bit ev, input bit em, input int e0, input int e1);
    rd_valid = 1'b1;
    rd_x     = HB'(x);
    rd_y     = VB'(y);
    rd_z     = 32'(zd) << 16;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    check_eq({tag, "_ab0"}, 64'(sram_ab[y % NL]), 64'(x));
    check_eq({tag, "_ab1"}, 64'(sram_ab[(y + 1) % NL]), 64'(x));
    check_eq({tag, "_ab_idle"}, 64'(sram_ab[(y + 2) % NL]), 64'h3FF);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_valid"}, 64'(o_valid), 64'(ev));
    check_eq({tag, "_miss"}, 64'(o_miss), 64'(em));
    check_eq({tag, "_d0"}, 64'(o_depth0), 64'(e0));
    check_eq({tag, "_d1"}, 64'(o_depth1), 64'(e1));
    check_eq({tag, "_x"}, 64'(o_rd_x), 64'(x));
    check_eq({tag, "_y"}, 64'(o_rd_y), 64'(y));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 64'({o_valid, o_miss}), 64'd0);
  endtask

  initial begin
    int             ex, ey, pulses;
    logic [DB-1:0]  e0, e1;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    hsize       = 10'd8;
    vsize       = 10'd8;
    wr_valid    = 1'b0;
    wr_depth    = '0;
    rd_valid    = 1'b0;
    rd_x        = '0;
    rd_y        = '0;
    rd_z        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_miss", 64'(o_miss), 64'd0);
    check_eq("rst_depth", 64'({o_depth0, o_depth1}), 64'd0);
    check_eq("rst_pos", 64'({o_rd_x, o_rd_y}), 64'd0);
    check_eq("rst_wen", 64'(sram_wen), 64'hF);
    check_eq("rst_aa", 64'(sram_aa), 64'hFF_FFFF_FFFF);
    check_eq("rst_da", 64'(sram_da), 64'd0);
    check_eq("rst_ab", 64'(sram_ab), 64'hFF_FFFF_FFFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_read("pre_frame", 3, 0, 100, 1'b0, 1'b1, 0, 0);

    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    write_row(0);
    write_row(1);

    do_read("r30", 3, 0, 100, 1'b1, 1'b0, 100, 100);
    do_read("r32_miss", 3, 2, 100, 1'b0, 1'b1, 0, 0);
    do_read("r51", 5, 1, 100, 1'b1, 1'b0, 100, 0);
    do_read("z_out", 1, 0, 100 + 256, 1'b0, 1'b0, 100, 100);
    do_read("z_in", 1, 0, 100 + 255, 1'b1, 1'b0, 100, 100);
    do_read("z_below", 2, 1, 0, 1'b1, 1'b0, 100, 0);

    write_row(2);
    write_row(3);
    write_row(4);

    do_read("max_depth", 0, 2, 65535, 1'b0, 1'b0, 65535, 0);
    do_read("r12", 1, 2, 65534, 1'b1, 1'b0, 65534, 10);
    do_read("min_depth", 0, 3, 0, 1'b0, 1'b0, 0, 200);
    do_read("evicted", 0, 0, 100, 1'b0, 1'b1, 0, 100);
    do_read("row4", 0, 4, 200, 1'b1, 1'b0, 200, 0);
    do_read("r31", 3, 1, 100, 1'b1, 1'b0, 100, 65532);
    do_read("bank_wrap", 2, 3, 20, 1'b1, 1'b0, 20, 202);

    // Reads every cycle on rows 2/3 while row 5 streams into bank 1
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        rd_valid = 1'b1;
        rd_x     = HB'(k % 8);
        rd_y     = VB'(2 + k % 2);
        rd_z     = 32'(exp_depth(2 + k % 2, k % 8)) << 16;
      end else begin
        rd_valid = 1'b0;
      end
      wr_valid = (k < 8);
      wr_depth = exp_depth(5, k % 8);
      @(posedge clk); #1;
      if (k >= 3 && k < 19) begin
        ex = (k - 3) % 8;
        ey = 2 + (k - 3) % 2;
        e0 = exp_depth(ey, ex);
        e1 = exp_depth(ey + 1, ex);
        check_eq("b2b_valid", 64'(o_valid), 64'(e0 != 16'h0 && e0 != 16'hFFFF));
        check_eq("b2b_miss", 64'(o_miss), 64'd0);
        check_eq("b2b_x", 64'(o_rd_x), 64'(ex));
        check_eq("b2b_y", 64'(o_rd_y), 64'(ey));
        check_eq("b2b_d0", 64'(o_depth0), 64'(e0));
        check_eq("b2b_d1", 64'(o_depth1), 64'(e1));
      end
      if (k == 19) check_eq("b2b_idle", 64'({o_valid, o_miss}), 64'd0);
    end
    wr_valid = 1'b0;

    do_read("row5", 7, 5, 307, 1'b1, 1'b0, 307, 0);
    do_read("row2_kept", 4, 2, 65531, 1'b1, 1'b0, 65531, 40);
    do_read("row1_gone", 0, 1, 100, 1'b0, 1'b1, 0, 65535);

    // A 4-row frame size puts row 4 out of range for the y+1 lookup
    vsize = 10'd4;
    do_read("vsize_edge", 5, 3, 50, 1'b1, 1'b0, 50, 0);
    vsize = 10'd8;

    // Reset with two requests in flight
    rd_valid = 1'b1;
    rd_x     = 10'd1;
    rd_y     = 10'd4;
    rd_z     = 32'd200 << 16;
    @(posedge clk); #1;
    rd_y = 10'd0;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("flight_d0", 64'(o_depth0), 64'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_valid || o_miss) pulses++;
    end
    check_eq("flight_pulses", 64'(pulses), 64'd0);
    do_read("post_rst", 1, 4, 200, 1'b0, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
